// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt entry/return sequencer
package irq_pkg;

  // Sequencer states; IDLE must stay at zero so a cleared register means idle.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_SAVE_LR   = 3'd2,
    ST_SAVE_SPSR = 3'd3,
    ST_VECTOR    = 3'd4,
    ST_RET       = 3'd5
  } irq_state_e;

  // CPSR write source select driven to the datapath.
  typedef enum logic [1:0] {
    CPSR_SRC_ALU  = 2'd0,
    CPSR_SRC_SPSR = 2'd1,
    CPSR_SRC_IRQ  = 2'd2
  } cpsr_src_e;

  // Byte distance between consecutive source vectors.
  localparam logic [31:0] VEC_STRIDE = 32'd4;

  // Width of a source index; covers up to 16 sources.
  localparam int IDX_W = 4;

endpackage

// File: rtl/irq_seq_ctrl_if.sv
// rtl/irq_seq_ctrl_if.sv - request/strobe bundle between the main FSM and the IRQ sequencer
interface irq_seq_ctrl_if #(
  parameter int NUM_SRC = 4
);

  logic [NUM_SRC-1:0] irq_req;
  logic [NUM_SRC-1:0] irq_en;
  logic               cpsr_i;
  logic               instr_done;
  logic               eret;

  logic               busy;
  logic               resume;
  logic               lr_we;
  logic               spsr_we;
  logic               cpsr_we;
  logic               pc_we;
  logic [1:0]         cpsr_src;
  logic [31:0]        vec_pc;
  logic [NUM_SRC-1:0] inta;
  logic [2:0]         nest_lvl;
  logic               nest_ovf;

  // Main FSM / interrupt fabric side.
  modport master (
    output irq_req, irq_en, cpsr_i, instr_done, eret,
    input  busy, resume, lr_we, spsr_we, cpsr_we, pc_we,
    input  cpsr_src, vec_pc, inta, nest_lvl, nest_ovf
  );

  // Sequencer side.
  modport slave (
    input  irq_req, irq_en, cpsr_i, instr_done, eret,
    output busy, resume, lr_we, spsr_we, cpsr_we, pc_we,
    output cpsr_src, vec_pc, inta, nest_lvl, nest_ovf
  );

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_seq_ctrl.sv
// rtl/irq_seq_ctrl.sv - IRQ entry/return sequencer driving LR/SPSR/CPSR/PC write strobes
module irq_seq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC  = 4,
  parameter int          NEST_MAX = 3,
  parameter logic [31:0] VEC_BASE = 32'h0000_0018
) (
  input  logic          clk,
  input  logic          rst,
  irq_seq_ctrl_if.slave bus
);

  localparam logic [2:0] NEST_LIMIT = 3'(NEST_MAX);

  irq_state_e         state_q, state_d;

  logic [NUM_SRC-1:0] pending;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic               entry_req;
  logic               entry_ok;
  logic               entry_ovf;

  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic               busy_q, busy_d;
  logic               resume_q, resume_d;
  logic               lr_we_q, lr_we_d;
  logic               spsr_we_q, spsr_we_d;
  logic               cpsr_we_q, cpsr_we_d;
  logic               pc_we_q, pc_we_d;
  cpsr_src_e          cpsr_src_q, cpsr_src_d;
  logic [31:0]        vec_pc_q, vec_pc_d;
  logic [NUM_SRC-1:0] inta_q, inta_d;
  logic [2:0]         nest_lvl_q, nest_lvl_d;
  logic               nest_ovf_q, nest_ovf_d;

  assign pending = bus.irq_req & bus.irq_en;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req   (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // An exception return in the same cycle pre-empts entry; the request is
  // simply seen again at the next instruction boundary.
  assign entry_req = bus.instr_done && !bus.eret && enc_valid && !bus.cpsr_i;
  assign entry_ok  = entry_req && (nest_lvl_q < NEST_LIMIT);
  assign entry_ovf = entry_req && !(nest_lvl_q < NEST_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; pulses arriving outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.eret)     state_d = ST_RET;
        else if (entry_ok) state_d = ST_ARB;
      end
      ST_ARB:       state_d = ST_SAVE_LR;
      ST_SAVE_LR:   state_d = ST_SAVE_SPSR;
      ST_SAVE_SPSR: state_d = ST_VECTOR;
      ST_VECTOR:    state_d = ST_IDLE;
      ST_RET:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state so every strobe leaves a flop.
  always_comb begin
    win_idx_d  = win_idx_q;
    busy_d     = (state_d != ST_IDLE);
    lr_we_d    = 1'b0;
    spsr_we_d  = 1'b0;
    cpsr_we_d  = 1'b0;
    pc_we_d    = 1'b0;
    cpsr_src_d = CPSR_SRC_ALU;
    vec_pc_d   = vec_pc_q;
    inta_d     = '0;
    nest_lvl_d = nest_lvl_q;
    resume_d   = (state_d == ST_IDLE) &&
                 ((state_q == ST_VECTOR) || (state_q == ST_RET) ||
                  ((state_q == ST_IDLE) && bus.instr_done));
    nest_ovf_d = (state_q == ST_IDLE) && entry_ovf;

    // Winner is captured on entry so a request dropping later cannot
    // change which source gets vectored.
    if ((state_q == ST_IDLE) && (state_d == ST_ARB)) win_idx_d = enc_idx;

    case (state_d)
      ST_SAVE_LR:   lr_we_d   = 1'b1;
      ST_SAVE_SPSR: spsr_we_d = 1'b1;
      ST_VECTOR: begin
        cpsr_we_d  = 1'b1;
        pc_we_d    = 1'b1;
        cpsr_src_d = CPSR_SRC_IRQ;
        vec_pc_d   = VEC_BASE + VEC_STRIDE * 32'(win_idx_q);
        inta_d     = NUM_SRC'(1) << win_idx_q;
        nest_lvl_d = nest_lvl_q + 3'd1;
      end
      ST_RET: begin
        cpsr_we_d  = 1'b1;
        cpsr_src_d = CPSR_SRC_SPSR;
        if (nest_lvl_q != 3'd0) nest_lvl_d = nest_lvl_q - 3'd1;
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_idx_q  <= '0;
      busy_q     <= 1'b0;
      resume_q   <= 1'b0;
      lr_we_q    <= 1'b0;
      spsr_we_q  <= 1'b0;
      cpsr_we_q  <= 1'b0;
      pc_we_q    <= 1'b0;
      cpsr_src_q <= CPSR_SRC_ALU;
      vec_pc_q   <= VEC_BASE;
      inta_q     <= '0;
      nest_lvl_q <= 3'd0;
      nest_ovf_q <= 1'b0;
    end else begin
      win_idx_q  <= win_idx_d;
      busy_q     <= busy_d;
      resume_q   <= resume_d;
      lr_we_q    <= lr_we_d;
      spsr_we_q  <= spsr_we_d;
      cpsr_we_q  <= cpsr_we_d;
      pc_we_q    <= pc_we_d;
      cpsr_src_q <= cpsr_src_d;
      vec_pc_q   <= vec_pc_d;
      inta_q     <= inta_d;
      nest_lvl_q <= nest_lvl_d;
      nest_ovf_q <= nest_ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.resume   = resume_q;
  assign bus.lr_we    = lr_we_q;
  assign bus.spsr_we  = spsr_we_q;
  assign bus.cpsr_we  = cpsr_we_q;
  assign bus.pc_we    = pc_we_q;
  assign bus.cpsr_src = cpsr_src_q;
  assign bus.vec_pc   = vec_pc_q;
  assign bus.inta     = inta_q;
  assign bus.nest_lvl = nest_lvl_q;
  assign bus.nest_ovf = nest_ovf_q;

endmodule

// File: doc/irq_seq_ctrl.md
IRQ_SEQ_CTRL -- requirements
Module: irq_seq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources, 1..16.
REQ-002 Parameter NEST_MAX, default 3: maximum nesting depth, 1..7.
REQ-003 Parameter VEC_BASE, default 32'h0000_0018: vector of source 0.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 irq_req  in  NUM_SRC  level interrupt requests; bit i is source i.
REQ-007 irq_en  in  NUM_SRC  per-source enable mask.
REQ-008 cpsr_i  in  1  CPSR I bit; 1 blocks entry.
REQ-009 instr_done  in  1  one-cycle pulse from the main FSM at an instruction boundary.
REQ-010 eret  in  1  one-cycle pulse marking MOVS PC,LR completion (exception return).
REQ-011 busy  out  1  high while the sequencer owns the datapath.
REQ-012 resume  out  1  one-cycle pulse telling the main FSM to fetch next.
REQ-013 lr_we, spsr_we, cpsr_we, pc_we  out  1 each  datapath write strobes.
REQ-014 cpsr_src  out  2  CPSR source: 0 ALU, 1 SPSR restore, 2 IRQ entry (mode IRQ, I=1).
REQ-015 vec_pc  out  32  vector address driven to PC mux.
REQ-016 inta  out  NUM_SRC  one-hot acknowledge pulse.
REQ-017 nest_lvl  out  3  current nesting depth.
REQ-018 nest_ovf  out  1  one-cycle pulse when entry is refused for depth.

Function
REQ-019 Pending vector = irq_req & irq_en; winner = lowest set index (fixed priority).
REQ-020 States: IDLE, ARB, SAVE_LR, SAVE_SPSR, VECTOR, RET; encoding from the package.
REQ-021 IDLE: on instr_done with pending!=0 and cpsr_i==0 and nest_lvl<NEST_MAX, go ARB; otherwise assert resume next cycle and stay IDLE.
REQ-022 IDLE: on instr_done with entry qualified except nest_lvl==NEST_MAX, pulse nest_ovf, assert resume, stay IDLE.
REQ-023 ARB: latch winner index into win_idx; busy=1; no strobes.
REQ-024 SAVE_LR: lr_we=1 for one cycle (LR_irq <= PC+4 in datapath).
REQ-025 SAVE_SPSR: spsr_we=1 for one cycle (SPSR_irq <= CPSR).
REQ-026 VECTOR: cpsr_we=1, cpsr_src=2, pc_we=1, vec_pc=VEC_BASE+4*win_idx, inta[win_idx]=1, nest_lvl+1; next IDLE with resume pulse.
REQ-027 Entry latency instr_done to VECTOR = 4 cycles; resume one cycle after VECTOR.
REQ-028 eret in IDLE: go RET; RET drives cpsr_we=1, cpsr_src=1, nest_lvl-1 (saturate at 0); next IDLE with resume.
REQ-029 eret and instr_done same cycle: eret wins; interrupt re-evaluated at next instr_done.
REQ-030 Request dropping after ARB: sequence completes with latched win_idx.
REQ-031 instr_done or eret while busy: ignored.
REQ-032 All strobes and inta default 0 in every state not listed; outputs are registered decodes of next state.

Reset
REQ-033 rst asserted: state IDLE, nest_lvl 0, win_idx 0, all strobes/inta/nest_ovf/resume 0, busy 0, cpsr_src 0, vec_pc VEC_BASE.
REQ-034 rst mid-sequence abandons it without emitting remaining strobes.

Structure
REQ-035 Package irq_pkg holds state enum, cpsr_src codes, and vector stride constant (4).
REQ-036 Sub-module irq_prio_enc (NUM_SRC-wide lowest-index priority encoder with valid flag).

Verification
REQ-037 irq_req=4'b0110, irq_en=4'b1111, cpsr_i=0, instr_done -> inta=4'b0010, vec_pc=32'h1C, 4 cycles later, nest_lvl=1.
REQ-038 irq_req=4'b0001, cpsr_i=1, instr_done -> no strobes, resume next cycle.
REQ-039 Three nested entries with NEST_MAX=3, fourth instr_done with pending -> nest_ovf pulse, nest_lvl stays 3.
REQ-040 eret at nest_lvl=2 -> cpsr_we with cpsr_src=1, nest_lvl=1, resume.
REQ-041 eret and instr_done same cycle with pending -> RET taken, entry on following instr_done.
REQ-042 rst asserted during SAVE_SPSR -> all outputs at reset values, no inta emitted.
